dmem_access_unit: RTL and testbench

- Memory-stage load/store unit between the mips core's M-stage request and the byte-enabled data RAM.
- Converts a size/offset request into word-aligned RAM address, byte write-enables and replicated write data.
- Sign- or zero-extends load data and detects misaligned addresses.
- Sequences the access through a small FSM and stalls the pipeline until a RAM with configurable read latency responds.

---
 rtl/dmem_access_unit_if.sv | 33 +++
 rtl/dmem_access_unit.sv | 139 +++++++++++++
 tb/tb_dmem_access_unit.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_unit_if.sv
// Bus between the M-stage core/data RAM environment and the load/store unit.
// The slave modport is the unit's view; master is the core+RAM side.
interface dmem_access_unit_if;
    logic        req_en;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        adel_o;
    logic        ades_o;
    logic [31:0] badvaddr_o;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  req_en, req_wr, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        output stall_o, done_o, rdata_o, adel_o, ades_o, badvaddr_o,
               ram_en, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_en, req_wr, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        input  stall_o, done_o, rdata_o, adel_o, ades_o, badvaddr_o,
               ram_en, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store unit: aligns requests onto a byte-enabled RAM,
// extends load data, flags misaligned addresses and stalls for RD_LAT cycles.
module dmem_access_unit #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_access_unit_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;

    localparam logic [3:0] LAT = 4'(RD_LAT);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic        sgn_q;
    logic        wr_q;
    logic        ram_en_q;
    logic [3:0]  ram_we_q;
    logic [31:0] ram_addr_q;
    logic [31:0] ram_wdata_q;
    logic [31:0] rdata_q;
    logic        done_q;

    logic        misaligned;
    logic        accept;
    logic [1:0]  off;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic [31:0] rdata_d;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign off = bus.req_addr[1:0];

    always_comb begin
        misaligned = 1'b0;
        be_d       = 4'b1111;
        wdata_d    = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                be_d    = 4'b0001 << off;
                wdata_d = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = off[0];
                be_d       = 4'b0011 << off;
                wdata_d    = {2{bus.req_wdata[15:0]}};
            end
            2'b10: misaligned = |off;
            default: misaligned = 1'b1;
        endcase
    end

    assign accept = (state_q == IDLE) && bus.req_en && !misaligned;

    // Extraction uses the offset latched at accept, not the live request.
    assign rd_byte = bus.ram_rdata[{off_q, 3'b000} +: 8];
    assign rd_half = off_q[1] ? bus.ram_rdata[31:16] : bus.ram_rdata[15:0];

    always_comb begin
        case (size_q)
            2'b00:   rdata_d = {{24{sgn_q & rd_byte[7]}}, rd_byte};
            2'b01:   rdata_d = {{16{sgn_q & rd_half[15]}}, rd_half};
            default: rdata_d = bus.ram_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= '0;
            off_q       <= '0;
            sgn_q       <= 1'b0;
            wr_q        <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            // Enable and write strobes live for the ACCESS cycle only.
            ram_en_q <= 1'b0;
            ram_we_q <= '0;
            done_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        size_q      <= bus.req_size;
                        off_q       <= off;
                        sgn_q       <= bus.req_signed;
                        wr_q        <= bus.req_wr;
                        ram_en_q    <= 1'b1;
                        ram_we_q    <= bus.req_wr ? be_d : 4'b0000;
                        ram_addr_q  <= {bus.req_addr[31:2], 2'b00};
                        ram_wdata_q <= wdata_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wr_q) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= LAT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        rdata_q <= rdata_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.stall_o    = accept || (state_q == ACCESS) || (state_q == WAIT);
    assign bus.done_o     = done_q;
    assign bus.rdata_o    = rdata_q;
    assign bus.adel_o     = (state_q == IDLE) && bus.req_en && misaligned && !bus.req_wr;
    assign bus.ades_o     = (state_q == IDLE) && bus.req_en && misaligned && bus.req_wr;
    assign bus.badvaddr_o = bus.req_addr;
    assign bus.ram_en     = ram_en_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with RD_LAT=1 and RD_LAT=4 instances.
// Cycle 1 is the IDLE cycle in which a request is first presented.
module tb_dmem_access_unit;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    dmem_access_unit_if b1();
    dmem_access_unit_if b4();

    dmem_access_unit #(.RD_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_access_unit #(.RD_LAT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] exp, input string tag);
        b1.req_en = 1'b1; b1.req_wr = 1'b0; b1.req_size = sz;
        b1.req_signed = sg; b1.req_addr = a;
        #1 chk({tag, "_stall"}, 32'(b1.stall_o), 32'd1);
        tick(); tick(); tick();
        #1 chk({tag, "_done"}, 32'(b1.done_o), 32'd1);
        chk({tag, "_rdata"}, b1.rdata_o, exp);
        tick();
        b1.req_en = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst = 1'b1;
        b1.req_en = 0; b1.req_wr = 0; b1.req_size = 0; b1.req_signed = 0;
        b1.req_addr = 0; b1.req_wdata = 0; b1.ram_rdata = 0;
        b4.req_en = 0; b4.req_wr = 0; b4.req_size = 0; b4.req_signed = 0;
        b4.req_addr = 0; b4.req_wdata = 0; b4.ram_rdata = 0;
        tick(); tick();
        chk("rst_ram_en", 32'(b1.ram_en), 32'd0);
        chk("rst_ram_we", 32'(b1.ram_we), 32'd0);
        chk("rst_ram_addr", b1.ram_addr, 32'd0);
        chk("rst_ram_wdata", b1.ram_wdata, 32'd0);
        chk("rst_rdata", b1.rdata_o, 32'd0);
        chk("rst_done", 32'(b1.done_o), 32'd0);
        chk("rst_stall", 32'(b1.stall_o), 32'd0);
        rst = 1'b0;

        // Load word, RD_LAT=1
        b1.req_en = 1; b1.req_wr = 0; b1.req_size = 2'b10; b1.req_addr = 32'h100;
        b1.ram_rdata = 32'hDEADBEEF;
        #1 chk("lw_c1_stall", 32'(b1.stall_o), 32'd1);
        chk("lw_c1_ram_en", 32'(b1.ram_en), 32'd0);
        tick();
        #1 chk("lw_c2_ram_en", 32'(b1.ram_en), 32'd1);
        chk("lw_c2_ram_we", 32'(b1.ram_we), 32'd0);
        chk("lw_c2_ram_addr", b1.ram_addr, 32'h100);
        chk("lw_c2_stall", 32'(b1.stall_o), 32'd1);
        tick();
        #1 chk("lw_c3_ram_en", 32'(b1.ram_en), 32'd0);
        chk("lw_c3_stall", 32'(b1.stall_o), 32'd1);
        chk("lw_c3_done", 32'(b1.done_o), 32'd0);
        tick();
        #1 chk("lw_c4_done", 32'(b1.done_o), 32'd1);
        chk("lw_c4_stall", 32'(b1.stall_o), 32'd0);
        chk("lw_c4_rdata", b1.rdata_o, 32'hDEADBEEF);
        tick();
        b1.req_en = 0;
        #1 chk("lw_c5_done", 32'(b1.done_o), 32'd0);
        chk("lw_c5_rdata_held", b1.rdata_o, 32'hDEADBEEF);

        // Store byte 0xA5 at 0x203
        b1.req_en = 1; b1.req_wr = 1; b1.req_size = 2'b00; b1.req_addr = 32'h203;
        b1.req_wdata = 32'h000000A5;
        #1 chk("sb_c1_stall", 32'(b1.stall_o), 32'd1);
        tick();
        #1 chk("sb_c2_ram_en", 32'(b1.ram_en), 32'd1);
        chk("sb_c2_ram_we", 32'(b1.ram_we), 32'b1000);
        chk("sb_c2_ram_addr", b1.ram_addr, 32'h200);
        chk("sb_c2_ram_wdata", b1.ram_wdata, 32'hA5A5A5A5);
        tick();
        #1 chk("sb_c3_done", 32'(b1.done_o), 32'd1);
        chk("sb_c3_stall", 32'(b1.stall_o), 32'd0);
        chk("sb_c3_ram_we", 32'(b1.ram_we), 32'd0);
        chk("sb_c3_rdata_kept", b1.rdata_o, 32'hDEADBEEF);
        tick();
        b1.req_en = 0;

        // Sub-word loads from RAM word 0x12F03456
        b1.ram_rdata = 32'h12F03456;
        load1(2'b00, 1'b1, 32'h302, 32'hFFFFFFF0, "lb_signed");
        load1(2'b00, 1'b0, 32'h302, 32'h000000F0, "lbu");
        load1(2'b01, 1'b1, 32'h302, 32'h000012F0, "lh_signed");
        load1(2'b01, 1'b1, 32'h300, 32'h00003456, "lh_low");

        // Address errors
        b1.req_en = 1; b1.req_wr = 0; b1.req_size = 2'b01; b1.req_addr = 32'h101;
        #1 chk("adel", 32'(b1.adel_o), 32'd1);
        chk("adel_ades", 32'(b1.ades_o), 32'd0);
        chk("adel_badv", b1.badvaddr_o, 32'h101);
        chk("adel_stall", 32'(b1.stall_o), 32'd0);
        tick();
        #1 chk("adel_ram_en", 32'(b1.ram_en), 32'd0);
        chk("adel_done", 32'(b1.done_o), 32'd0);
        b1.req_wr = 1; b1.req_size = 2'b10; b1.req_addr = 32'h102;
        #1 chk("ades", 32'(b1.ades_o), 32'd1);
        chk("ades_adel", 32'(b1.adel_o), 32'd0);
        chk("ades_badv", b1.badvaddr_o, 32'h102);
        tick();
        #1 chk("ades_ram_en", 32'(b1.ram_en), 32'd0);
        b1.req_wr = 0; b1.req_size = 2'b11; b1.req_addr = 32'h100;
        #1 chk("size11_adel", 32'(b1.adel_o), 32'd1);
        chk("size11_stall", 32'(b1.stall_o), 32'd0);
        tick();
        #1 chk("size11_ram_en", 32'(b1.ram_en), 32'd0);
        b1.req_en = 0;
        #1 chk("noreq_adel", 32'(b1.adel_o), 32'd0);

        // RD_LAT=4 load, data present only in the capture cycle
        b4.req_en = 1; b4.req_wr = 0; b4.req_size = 2'b10; b4.req_addr = 32'h400;
        b4.ram_rdata = 32'h0;
        #1 chk("l4_c1_stall", 32'(b4.stall_o), 32'd1);
        tick();
        #1 chk("l4_c2_ram_en", 32'(b4.ram_en), 32'd1);
        chk("l4_c2_ram_addr", b4.ram_addr, 32'h400);
        for (int c = 3; c <= 5; c++) begin
            tick();
            #1 chk("l4_wait_stall", 32'(b4.stall_o), 32'd1);
            chk("l4_wait_done", 32'(b4.done_o), 32'd0);
            chk("l4_wait_ram_en", 32'(b4.ram_en), 32'd0);
        end
        tick();
        b4.ram_rdata = 32'hCAFEF00D;
        #1 chk("l4_c6_done", 32'(b4.done_o), 32'd0);
        chk("l4_c6_stall", 32'(b4.stall_o), 32'd1);
        tick();
        b4.ram_rdata = 32'h0;
        #1 chk("l4_c7_done", 32'(b4.done_o), 32'd1);
        chk("l4_c7_rdata", b4.rdata_o, 32'hCAFEF00D);
        chk("l4_c7_stall", 32'(b4.stall_o), 32'd0);
        tick();
        b4.req_wr = 1; b4.req_size = 2'b10; b4.req_addr = 32'h404; b4.req_wdata = 32'h11223344;
        #1 chk("s4_c8_stall", 32'(b4.stall_o), 32'd1);
        tick();
        #1 chk("s4_c9_ram_en", 32'(b4.ram_en), 32'd1);
        chk("s4_c9_ram_we", 32'(b4.ram_we), 32'b1111);
        chk("s4_c9_ram_addr", b4.ram_addr, 32'h404);
        chk("s4_c9_ram_wdata", b4.ram_wdata, 32'h11223344);
        tick();
        #1 chk("s4_c10_done", 32'(b4.done_o), 32'd1);
        chk("s4_c10_rdata_kept", b4.rdata_o, 32'hCAFEF00D);
        tick();
        b4.req_en = 0;

        // Reset during WAIT discards the load
        b4.req_en = 1; b4.req_wr = 0; b4.req_size = 2'b10; b4.req_addr = 32'h500;
        b4.ram_rdata = 32'h55555555;
        tick();
        tick();
        rst = 1'b1;
        #1 chk("rw_pre_stall", 32'(b4.stall_o), 32'd1);
        tick();
        rst = 1'b0; b4.req_en = 0;
        #1 chk("rw_stall", 32'(b4.stall_o), 32'd0);
        chk("rw_ram_en", 32'(b4.ram_en), 32'd0);
        chk("rw_rdata", b4.rdata_o, 32'd0);
        chk("rw_done", 32'(b4.done_o), 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            #1 chk("rw_no_done", 32'(b4.done_o), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
